// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform DMA path: arbiter state encoding and
// default DMA handshake widths.
package waveform_pkg;

  localparam int DMA_ADDR_WID = 32;
  localparam int DMA_WORD_WID = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DELIVER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/round_robin_pick.sv
// Combinational round-robin winner select: first set request at or after ptr,
// wrapping back to the lowest set request.
module round_robin_pick #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [N_REQ-1:0] upper;
  logic [N_REQ-1:0] pool;

  always_comb begin
    upper = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
    // Nothing at or above ptr means the search wraps to the bottom.
    pool   = (|upper) ? upper : req;
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pool[i]) winner = IDX_W'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/dma_read_arbiter.sv
// Round-robin sharing of one DMA read port among N_REQ BRAM refresh engines,
// one outstanding read at a time. Optional ISSUE timeout: DMA_ARB_TIMEOUT_EN.
//
// state      | meaning
// ST_IDLE    | no transaction; pick next requester from ptr
// ST_ISSUE   | ram_read high to DMA, waiting for ram_valid
// ST_DELIVER | word held for requester until it and the DMA release
module dma_read_arbiter
  import waveform_pkg::*;
#(
  parameter  int N_REQ            = 2,
  parameter  int RAM_WID          = DMA_ADDR_WID,
  parameter  int RAM_WORD_WID     = DMA_WORD_WID,
`ifdef DMA_ARB_TIMEOUT_EN
  parameter  int TIMEOUT_CNTR_LEN = 8,
  parameter  int TIMEOUT          = 200,
`endif
  localparam int IDX_W            = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*RAM_WID-1:0]   req_addr,
  input  logic [N_REQ-1:0]           req_read,
  output logic [RAM_WORD_WID-1:0]    req_word,
  output logic [N_REQ-1:0]           req_valid,
  output logic [RAM_WID-1:0]         ram_dma_addr,
  output logic                       ram_read,
  input  logic [RAM_WORD_WID-1:0]    ram_word,
  input  logic                       ram_valid,
  output logic [IDX_W-1:0]           grant,
  output logic                       busy
`ifdef DMA_ARB_TIMEOUT_EN
  ,
  output logic                       timeout_err
`endif
);

  arb_state_t              state, state_nxt;
  logic [IDX_W-1:0]        ptr, ptr_nxt;
  logic [IDX_W-1:0]        grant_nxt;
  logic [RAM_WID-1:0]      addr_nxt;
  logic                    ram_read_nxt;
  logic [RAM_WORD_WID-1:0] word_nxt;
  logic [N_REQ-1:0]        valid_nxt;
  logic                    busy_nxt;
  logic                    cancel, cancel_nxt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic [RAM_WID-1:0]      addr_arr [N_REQ];

`ifdef DMA_ARB_TIMEOUT_EN
  logic [TIMEOUT_CNTR_LEN-1:0] tmo_cnt, tmo_cnt_nxt;
  logic                        err_nxt;
`endif

  round_robin_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req_read),
    .ptr    (ptr),
    .winner (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_addr[i*RAM_WID +: RAM_WID];
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    grant_nxt    = grant;
    addr_nxt     = ram_dma_addr;
    ram_read_nxt = ram_read;
    word_nxt     = req_word;
    valid_nxt    = req_valid;
    cancel_nxt   = cancel;
`ifdef DMA_ARB_TIMEOUT_EN
    tmo_cnt_nxt  = tmo_cnt;
    err_nxt      = timeout_err;
`endif
    case (state)
      ST_IDLE: begin
        valid_nxt  = '0;
        cancel_nxt = 1'b0;
        if (pick_any) begin
          grant_nxt    = pick_idx;
          addr_nxt     = addr_arr[pick_idx];
          ram_read_nxt = 1'b1;
          state_nxt    = ST_ISSUE;
`ifdef DMA_ARB_TIMEOUT_EN
          // Down-counter sized so ram_read stays high exactly TIMEOUT cycles.
          tmo_cnt_nxt  = TIMEOUT_CNTR_LEN'(TIMEOUT - 1);
`endif
        end
      end
      ST_ISSUE: begin
        if (!req_read[grant]) cancel_nxt = 1'b1;
        if (ram_valid) begin
          word_nxt         = ram_word;
          ram_read_nxt     = 1'b0;
          valid_nxt        = '0;
          valid_nxt[grant] = !cancel_nxt;
          state_nxt        = ST_DELIVER;
        end
`ifdef DMA_ARB_TIMEOUT_EN
        else if (tmo_cnt == '0) begin
          word_nxt         = '0;
          ram_read_nxt     = 1'b0;
          err_nxt          = 1'b1;
          valid_nxt        = '0;
          valid_nxt[grant] = !cancel_nxt;
          state_nxt        = ST_DELIVER;
        end else begin
          tmo_cnt_nxt = tmo_cnt - 1'b1;
        end
`endif
      end
      ST_DELIVER: begin
        if (!req_read[grant] && !ram_valid) begin
          valid_nxt = '0;
          ptr_nxt   = (int'(grant) == N_REQ - 1) ? '0 : grant + IDX_W'(1);
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      grant        <= '0;
      ram_dma_addr <= '0;
      ram_read     <= 1'b0;
      req_word     <= '0;
      req_valid    <= '0;
      busy         <= 1'b0;
      cancel       <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
      tmo_cnt      <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      grant        <= grant_nxt;
      ram_dma_addr <= addr_nxt;
      ram_read     <= ram_read_nxt;
      req_word     <= word_nxt;
      req_valid    <= valid_nxt;
      busy         <= busy_nxt;
      cancel       <= cancel_nxt;
`ifdef DMA_ARB_TIMEOUT_EN
      tmo_cnt      <= tmo_cnt_nxt;
      timeout_err  <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Directed bench for dma_read_arbiter (N_REQ=4) with a behavioural DMA slave.
module tb_dma_read_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int WW    = 16;
  localparam int IDX_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_read = '0;
  logic [WW-1:0]   req_word;
  logic [N-1:0]    req_valid;
  logic [AW-1:0]   ram_dma_addr;
  logic            ram_read;
  logic [WW-1:0]   ram_word = '0;
  logic            ram_valid = 1'b0;
  logic [IDX_W-1:0] grant;
  logic            busy;
`ifdef DMA_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  int total = 0;
  int passed = 0;
  int dma_delay = 3;
  bit dma_mute = 1'b0;
  int dma_cnt = 0;

  dma_read_arbiter #(
    .N_REQ(N), .RAM_WID(AW), .RAM_WORD_WID(WW)
`ifdef DMA_ARB_TIMEOUT_EN
    , .TIMEOUT_CNTR_LEN(8), .TIMEOUT(20)
`endif
  ) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_read(req_read),
    .req_word(req_word), .req_valid(req_valid), .ram_dma_addr(ram_dma_addr),
    .ram_read(ram_read), .ram_word(ram_word), .ram_valid(ram_valid),
    .grant(grant), .busy(busy)
`ifdef DMA_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Main RAM contents: word at addr is addr[19:4] ^ 16'hACDB.
  function automatic logic [WW-1:0] ram_data(input logic [AW-1:0] a);
    return a[19:4] ^ 16'hACDB;
  endfunction

  // DMA slave: answers dma_delay cycles after it first sees ram_read.
  always @(posedge clk) begin
    if (!ram_read) begin
      ram_valid <= 1'b0;
      dma_cnt   <= 0;
    end else if (!ram_valid) begin
      if (!dma_mute && dma_cnt >= dma_delay - 1) begin
        ram_valid <= 1'b1;
        ram_word  <= ram_data(ram_dma_addr);
      end else begin
        dma_cnt <= dma_cnt + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (req_valid == '0 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_wait_valid"}, 32'(n < 100), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_wait_idle"}, 32'(n < 100), 32'd1);
  endtask

  // Wait for delivery to exp_g; then release it (re-arm) or clear every request.
  task automatic serve(input string tag, input int exp_g, input logic [WW-1:0] exp_w,
                       input bit rearm);
    wait_valid(tag);
    chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
    chk({tag, "_valid"}, 32'(req_valid), 32'(1 << exp_g));
    chk({tag, "_word"}, 32'(req_word), 32'(exp_w));
    if (rearm) req_read[exp_g] = 1'b0;
    else       req_read = '0;
    wait_idle(tag);
    if (rearm) req_read[exp_g] = 1'b1;
  endtask

  initial begin
    bit saw_req_valid;
    bit saw_ram_valid;
    int n;
    req_addr = {32'h0000_FF00, 32'h0009_ABC0, 32'h0005_6780, 32'h0001_2340};

    // Reset values
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_word", 32'(req_word), 32'h0);
    chk("rst_valid", 32'(req_valid), 32'h0);
    chk("rst_addr", ram_dma_addr, 32'h0);
    chk("rst_read", 32'(ram_read), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
`ifdef DMA_ARB_TIMEOUT_EN
    chk("rst_tmo", 32'(timeout_err), 32'h0);
`endif

    // Requesters 0 and 1 together from ptr 0: 0,1,0,1
    dma_delay = 3;
    req_read = 4'b0011;
    serve("pair0", 0, 16'hBEEF, 1'b1);
    serve("pair1", 1, 16'hFAA3, 1'b1);
    serve("pair2", 0, 16'hBEEF, 1'b1);
    serve("pair3", 1, 16'hFAA3, 1'b0);

    // Single requester 0, DMA delay 12; address change after grant is ignored
    dma_delay = 12;
    req_read = 4'b0001;
    tick();
    chk("single_read_lat", 32'(ram_read), 32'd1);
    chk("single_grant", 32'(grant), 32'd0);
    chk("single_addr", ram_dma_addr, 32'h0001_2340);
    req_addr[31:0] = 32'h0007_7770;
    tick();
    chk("single_addr_hold", ram_dma_addr, 32'h0001_2340);
    serve("single", 0, 16'hBEEF, 1'b0);
    req_addr[31:0] = 32'h0001_2340;
    chk("single_release", 32'(req_valid), 32'h0);

    // Requester 1 cancels mid-ISSUE
    dma_delay = 5;
    req_read = 4'b0010;
    tick();
    chk("cancel_grant", 32'(grant), 32'd1);
    tick();
    req_read = 4'b0000;
    saw_req_valid = 1'b0;
    saw_ram_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (req_valid != '0) saw_req_valid = 1'b1;
      if (ram_valid) saw_ram_valid = 1'b1;
    end
    chk("cancel_idle", 32'(n < 100), 32'd1);
    chk("cancel_no_valid", 32'(saw_req_valid), 32'd0);
    chk("cancel_dma_done", 32'(saw_ram_valid), 32'd1);
    // ptr moved past requester 1, so 2 beats 0
    req_read = 4'b0101;
    serve("after_cancel", 2, 16'h3667, 1'b0);

    // Reset pulsed during ISSUE
    dma_delay = 10;
    req_read = 4'b1000;
    tick(); tick(); tick();
    chk("rstiss_read", 32'(ram_read), 32'd1);
    rst = 1'b1;
    req_read = '0;
    tick();
    chk("rstiss_word", 32'(req_word), 32'h0);
    chk("rstiss_valid", 32'(req_valid), 32'h0);
    chk("rstiss_addr", ram_dma_addr, 32'h0);
    chk("rstiss_read0", 32'(ram_read), 32'h0);
    chk("rstiss_grant", 32'(grant), 32'h0);
    chk("rstiss_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(); tick();

    // All four requesting after reset: 0,1,2,3,0
    dma_delay = 2;
    req_read = 4'b1111;
    serve("all0", 0, 16'hBEEF, 1'b1);
    serve("all1", 1, 16'hFAA3, 1'b1);
    serve("all2", 2, 16'h3667, 1'b1);
    serve("all3", 3, 16'hA32B, 1'b1);
    serve("all4", 0, 16'hBEEF, 1'b0);

    // Only 1 and 3 active: 1,3,1,3
    req_read = 4'b1010;
    serve("odd0", 1, 16'hFAA3, 1'b1);
    serve("odd1", 3, 16'hA32B, 1'b1);
    serve("odd2", 1, 16'hFAA3, 1'b1);
    serve("odd3", 3, 16'hA32B, 1'b0);

`ifdef DMA_ARB_TIMEOUT_EN
    // DMA never answers: abort after 20 ISSUE cycles
    dma_mute = 1'b1;
    req_read = 4'b0001;
    tick();
    chk("tmo_read", 32'(ram_read), 32'd1);
    n = 0;
    while (ram_read && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd20);
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_word", 32'(req_word), 32'h0);
    chk("tmo_valid", 32'(req_valid), 32'h1);
    req_read = '0;
    wait_idle("tmo");
    chk("tmo_valid_clr", 32'(req_valid), 32'h0);
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
    dma_mute = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
